// File: rtl/hps_upload_responder.sv
// hps_upload_responder: serves HPS 16-bit upload reads from a byte memory.
// Ports: clk_sys/reset, ioctl_* HPS side, mem_* memory side, status outputs.
module hps_upload_responder #(
  parameter int MEM_AW  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  input  logic [24:0]       ioctl_addr,
  output logic [15:0]       ioctl_din,
  output logic              ioctl_wait,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_din,
  input  logic              mem_ack,
  output logic [7:0]        mem_region,
  output logic              upload_done,
  output logic [15:0]       word_count,
  output logic              upload_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ_LO,
    REQ_HI
  } state_t;

  state_t            state;
  logic              upload_q;
  logic [MEM_AW-1:0] base;
  logic [7:0]        lo;
  logic [7:0]        cnt;
  logic              tmo;
  logic [7:0]        byte_in;

  // Byte phase gives up after TIMEOUT cycles with no ack
  assign tmo = (cnt == 8'(TIMEOUT - 1));

  // A timed-out byte reads as all ones
  assign byte_in = mem_ack ? mem_din : 8'hFF;

  assign ioctl_wait = (ioctl_rd & ioctl_upload & (state == IDLE))
                    | (state != IDLE);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      upload_q    <= 1'b0;
      base        <= '0;
      lo          <= '0;
      cnt         <= '0;
      ioctl_din   <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      mem_region  <= '0;
      upload_done <= 1'b0;
      word_count  <= '0;
      upload_err  <= 1'b0;
    end else begin
      upload_q    <= ioctl_upload;
      mem_rd      <= 1'b0;
      upload_done <= upload_q & ~ioctl_upload;

      if (ioctl_upload & ~upload_q) begin
        mem_region <= ioctl_index;
        word_count <= '0;
        upload_err <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (ioctl_upload & ioctl_rd) begin
            base     <= {ioctl_addr[MEM_AW-1:1], 1'b0};
            mem_addr <= {ioctl_addr[MEM_AW-1:1], 1'b0};
            mem_rd   <= 1'b1;
            cnt      <= '0;
            state    <= REQ_LO;
          end
        end
        REQ_LO: begin
          // Session dropped: abandon the word silently
          if (!ioctl_upload) begin
            state <= IDLE;
          end else if (mem_ack | tmo) begin
            lo       <= byte_in;
            mem_addr <= base + MEM_AW'(1);
            mem_rd   <= 1'b1;
            cnt      <= '0;
            state    <= REQ_HI;
            if (!mem_ack) upload_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        REQ_HI: begin
          if (!ioctl_upload) begin
            state <= IDLE;
          end else if (mem_ack | tmo) begin
            ioctl_din  <= {byte_in, lo};
            word_count <= word_count + 16'd1;
            state      <= IDLE;
            if (!mem_ack) upload_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
